// File: rtl/reg_file_if.sv
// Bundle of the decode read ports, writeback port, pending-issue port and stall
// request shared between the pipeline (master) and the register file (slave).
interface reg_file_if #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
);
  logic [REG_ADDR_LEN-1:0] Rd1_addr;
  logic                    Rd1_en;
  logic [WIDTH-1:0]        Rd1_data;
  logic                    Rd1_st;
  logic [REG_ADDR_LEN-1:0] Rd2_addr;
  logic                    Rd2_en;
  logic [WIDTH-1:0]        Rd2_data;
  logic                    Rd2_st;
  logic [REG_ADDR_LEN-1:0] Wr_addr;
  logic [WIDTH-1:0]        Wr_data;
  logic                    Wr_en;
  logic [REG_ADDR_LEN-1:0] Pend_addr;
  logic                    Pend_en;
  logic                    Stall_out;

  modport master (
    output Rd1_addr, Rd1_en, Rd2_addr, Rd2_en,
    output Wr_addr, Wr_data, Wr_en, Pend_addr, Pend_en,
    input  Rd1_data, Rd1_st, Rd2_data, Rd2_st, Stall_out
  );

  modport slave (
    input  Rd1_addr, Rd1_en, Rd2_addr, Rd2_en,
    input  Wr_addr, Wr_data, Wr_en, Pend_addr, Pend_en,
    output Rd1_data, Rd1_st, Rd2_data, Rd2_st, Stall_out
  );
endinterface

// File: rtl/reg_file.sv
// Register file with pending scoreboard, two parking read ports and stall request.
// Define RF_WR_BYPASS_EN to forward same-cycle writeback data on a read/write collision.
module reg_file #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);
  localparam int DEPTH = 2 ** REG_ADDR_LEN;
  localparam logic [REG_ADDR_LEN-1:0] ZERO_ADDR = {REG_ADDR_LEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_COLL = 2'd2
  } rd_state_e;

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]        pend_q, pend_d;
  rd_state_e               state_q [2];
  rd_state_e               state_d [2];
  logic [REG_ADDR_LEN-1:0] addr_q [2];
  logic [REG_ADDR_LEN-1:0] addr_d [2];
  logic [WIDTH-1:0]        data_q [2];
  logic [WIDTH-1:0]        data_d [2];
  logic [1:0]              st_q, st_d;
  logic                    stall_q, stall_d;
  logic [REG_ADDR_LEN-1:0] rd_addr_s [2];
  logic [1:0]              rd_en_s;

  // A write to r0 never happens, so r0 can never collide with a read.
  function automatic logic wr_hit(input logic we,
                                  input logic [REG_ADDR_LEN-1:0] wa,
                                  input logic [REG_ADDR_LEN-1:0] ra);
    return we && (wa == ra) && (ra != ZERO_ADDR);
  endfunction

  assign rd_addr_s[0] = bus.Rd1_addr;
  assign rd_addr_s[1] = bus.Rd2_addr;
  assign rd_en_s      = {bus.Rd2_en, bus.Rd1_en};

  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (bus.Wr_en && (bus.Wr_addr != ZERO_ADDR)) begin
      mem_d[bus.Wr_addr]  = bus.Wr_data;
      pend_d[bus.Wr_addr] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    // Setting after clearing lets a newly issued producer win over the writeback.
    if (bus.Pend_en && (bus.Pend_addr != ZERO_ADDR)) begin
      pend_d[bus.Pend_addr] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      addr_d[p]  = addr_q[p];
      data_d[p]  = data_q[p];
      st_d[p]    = 1'b0;
      case (state_q[p])
        ST_IDLE: begin
          if (rd_en_s[p]) begin
            if (wr_hit(bus.Wr_en, bus.Wr_addr, rd_addr_s[p])) begin
`ifdef RF_WR_BYPASS_EN
              data_d[p] = bus.Wr_data;
              st_d[p]   = 1'b1;
`else
              state_d[p] = ST_COLL;
              addr_d[p]  = rd_addr_s[p];
`endif
            end else if (pend_q[rd_addr_s[p]]) begin
              state_d[p] = ST_WAIT;
              addr_d[p]  = rd_addr_s[p];
            end else begin
              data_d[p] = mem_q[rd_addr_s[p]];
              st_d[p]   = 1'b1;
            end
          end else begin
            st_d[p] = 1'b0;
          end
        end
        ST_WAIT: begin
          if (wr_hit(bus.Wr_en, bus.Wr_addr, addr_q[p])) begin
            data_d[p]  = bus.Wr_data;
            st_d[p]    = 1'b1;
            state_d[p] = ST_IDLE;
          end else begin
            state_d[p] = ST_WAIT;
          end
        end
        ST_COLL: begin
          data_d[p]  = mem_q[addr_q[p]];
          st_d[p]    = 1'b1;
          state_d[p] = ST_IDLE;
        end
        default: begin
          state_d[p] = ST_IDLE;
        end
      endcase
    end
    stall_d = (state_d[0] == ST_WAIT) || (state_d[1] == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      pend_q <= {DEPTH{1'b0}};
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= ST_IDLE;
        addr_q[p]  <= ZERO_ADDR;
        data_q[p]  <= {WIDTH{1'b0}};
      end
      st_q    <= 2'b00;
      stall_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      st_q    <= st_d;
      stall_q <= stall_d;
    end
  end

  assign bus.Rd1_data  = data_q[0];
  assign bus.Rd2_data  = data_q[1];
  assign bus.Rd1_st    = st_q[0];
  assign bus.Rd2_st    = st_q[1];
  assign bus.Stall_out = stall_q;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected strobes are queued with their due cycle
// and every cycle both strobes, due data and the stall request are compared.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

`ifdef RF_WR_BYPASS_EN
  localparam int COLL_LAT = 1;
`else
  localparam int COLL_LAT = 2;
`endif

  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  reg_file_if bus ();
  reg_file dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input int port, input int lat, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.due  = cyc + lat;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick(input logic exp_stall);
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      logic        hit;
      logic [31:0] ed;
      logic        st_obs;
      logic [31:0] d_obs;
      hit    = 1'b0;
      ed     = 32'h0;
      st_obs = (p == 0) ? bus.Rd1_st : bus.Rd2_st;
      d_obs  = (p == 0) ? bus.Rd1_data : bus.Rd2_data;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].port == p && sb[i].due == cyc) begin
          hit = 1'b1;
          ed  = sb[i].data;
          sb.delete(i);
          break;
        end
      end
      chk($sformatf("st%0d@%0d", p + 1, cyc), {31'h0, st_obs}, {31'h0, hit});
      if (hit) chk($sformatf("data%0d@%0d", p + 1, cyc), d_obs, ed);
    end
    chk($sformatf("stall@%0d", cyc), {31'h0, bus.Stall_out}, {31'h0, exp_stall});
  endtask

  initial begin
    rst = 1'b1;
    bus.Rd1_addr = 5'd0; bus.Rd1_en = 1'b0;
    bus.Rd2_addr = 5'd0; bus.Rd2_en = 1'b0;
    bus.Wr_addr = 5'd0; bus.Wr_data = 32'h0; bus.Wr_en = 1'b0;
    bus.Pend_addr = 5'd0; bus.Pend_en = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("rst_data1", bus.Rd1_data, 32'h0);
    chk("rst_data2", bus.Rd2_data, 32'h0);
    rst = 1'b0;

    // Read of a reset register
    bus.Rd1_addr = 5'd7; bus.Rd1_en = 1'b1; expect_rd(0, 1, 32'h0);
    tick(1'b0);
    bus.Rd1_en = 1'b0;

    // Write then dual read of the same register
    bus.Wr_addr = 5'd3; bus.Wr_data = 32'hDEADBEEF; bus.Wr_en = 1'b1;
    tick(1'b0);
    bus.Wr_en = 1'b0;
    tick(1'b0);
    bus.Rd1_addr = 5'd3; bus.Rd1_en = 1'b1; expect_rd(0, 1, 32'hDEADBEEF);
    bus.Rd2_addr = 5'd3; bus.Rd2_en = 1'b1; expect_rd(1, 1, 32'hDEADBEEF);
    tick(1'b0);
    bus.Rd1_en = 1'b0; bus.Rd2_en = 1'b0;

    // Pending read parks; address changes and unrelated writes do not wake it
    bus.Pend_addr = 5'd5; bus.Pend_en = 1'b1;
    tick(1'b0);
    bus.Pend_en = 1'b0;
    bus.Rd2_addr = 5'd5; bus.Rd2_en = 1'b1;
    tick(1'b1);
    bus.Rd2_addr = 5'd3;
    bus.Wr_addr = 5'd8; bus.Wr_data = 32'h99; bus.Wr_en = 1'b1;
    tick(1'b1);
    bus.Wr_en = 1'b0;
    tick(1'b1);
    bus.Wr_addr = 5'd5; bus.Wr_data = 32'h1234; bus.Wr_en = 1'b1; expect_rd(1, 1, 32'h1234);
    tick(1'b0);
    bus.Wr_en = 1'b0; bus.Rd2_en = 1'b0;

    // Pend, write and read of r9 together: write lands, r9 stays pending
    bus.Pend_addr = 5'd9; bus.Pend_en = 1'b1;
    bus.Wr_addr = 5'd9; bus.Wr_data = 32'hAA; bus.Wr_en = 1'b1;
    bus.Rd1_addr = 5'd9; bus.Rd1_en = 1'b1; expect_rd(0, COLL_LAT, 32'hAA);
    tick(1'b0);
    bus.Pend_en = 1'b0; bus.Wr_en = 1'b0; bus.Rd1_en = 1'b0;
    tick(1'b0);
    bus.Rd1_addr = 5'd9; bus.Rd1_en = 1'b1;
    tick(1'b1);
    tick(1'b1);
    bus.Wr_addr = 5'd9; bus.Wr_data = 32'hBB; bus.Wr_en = 1'b1; expect_rd(0, 1, 32'hBB);
    tick(1'b0);
    bus.Wr_en = 1'b0; bus.Rd1_en = 1'b0;

    // Collision on a non-pending register, then a plain re-read of it
    bus.Wr_addr = 5'd4; bus.Wr_data = 32'h55; bus.Wr_en = 1'b1;
    bus.Rd1_addr = 5'd4; bus.Rd1_en = 1'b1; expect_rd(0, COLL_LAT, 32'h55);
    tick(1'b0);
    bus.Wr_en = 1'b0; bus.Rd1_en = 1'b0;
    tick(1'b0);
    bus.Rd2_addr = 5'd4; bus.Rd2_en = 1'b1; expect_rd(1, 1, 32'h55);
    tick(1'b0);
    bus.Rd2_en = 1'b0;

    // r0 ignores writes and pending marks
    bus.Wr_addr = 5'd0; bus.Wr_data = 32'hFF; bus.Wr_en = 1'b1;
    bus.Pend_addr = 5'd0; bus.Pend_en = 1'b1;
    tick(1'b0);
    bus.Wr_en = 1'b0; bus.Pend_en = 1'b0;
    bus.Rd1_addr = 5'd0; bus.Rd1_en = 1'b1; expect_rd(0, 1, 32'h0);
    tick(1'b0);

    // Back-to-back stream with en held high
    bus.Rd1_addr = 5'd3; expect_rd(0, 1, 32'hDEADBEEF);
    tick(1'b0);
    bus.Rd1_addr = 5'd4; expect_rd(0, 1, 32'h55);
    tick(1'b0);
    bus.Rd1_addr = 5'd7; expect_rd(0, 1, 32'h0);
    tick(1'b0);
    bus.Rd1_en = 1'b0;

    // Reset while port 1 waits aborts the read and clears state
    bus.Pend_addr = 5'd6; bus.Pend_en = 1'b1;
    tick(1'b0);
    bus.Pend_en = 1'b0;
    bus.Rd1_addr = 5'd6; bus.Rd1_en = 1'b1;
    tick(1'b1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0; bus.Rd1_en = 1'b0;
    chk("rst_wait_data1", bus.Rd1_data, 32'h0);
    bus.Wr_addr = 5'd6; bus.Wr_data = 32'h77; bus.Wr_en = 1'b1;
    tick(1'b0);
    bus.Wr_en = 1'b0;
    bus.Rd1_addr = 5'd6; bus.Rd1_en = 1'b1; expect_rd(0, 1, 32'h77);
    bus.Rd2_addr = 5'd3; bus.Rd2_en = 1'b1; expect_rd(1, 1, 32'h0);
    tick(1'b0);
    bus.Rd1_en = 1'b0; bus.Rd2_en = 1'b0;
    tick(1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
